// File: rtl/pe_row_ctrl_pkg.sv
// pe_row_ctrl_pkg: shared defaults and FSM state encoding for the PE row sequencer.
package pe_row_ctrl_pkg;
   localparam int NUM_PE_DEF    = 3;
   localparam int MUL_LAT_DEF   = 3;
   localparam int CNT_WIDTH_DEF = 8;
   typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;
endpackage

// File: rtl/pe_row_ctrl_if.sv
// pe_row_ctrl_if: scheduler, weight/data source and PE-row signals of the row sequencer.
interface pe_row_ctrl_if
   import pe_row_ctrl_pkg::*;
#(
   parameter int NUM_PE    = NUM_PE_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
   logic                 start_i;
   logic [CNT_WIDTH-1:0] num_out_i;
   logic                 weight_req_o;
   logic                 weight_val_i;
   logic [NUM_PE-1:0]    pe_weight_val_o;
   logic                 data_req_o;
   logic                 data_val_i;
   logic                 pe_data_val_o;
   logic                 psum_val_i;
   logic [CNT_WIDTH-1:0] out_cnt_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 err_o;
   modport slave (
      input  start_i, num_out_i, weight_val_i, data_val_i, psum_val_i,
      output weight_req_o, pe_weight_val_o, data_req_o, pe_data_val_o, out_cnt_o, busy_o, done_o, err_o
   );
   modport master (
      output start_i, num_out_i, weight_val_i, data_val_i, psum_val_i,
      input  weight_req_o, pe_weight_val_o, data_req_o, pe_data_val_o, out_cnt_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/pe_row_ctrl.sv
// pe_row_ctrl: loads one weight per PE, streams n data words to the row, then counts psum returns.
module pe_row_ctrl
   import pe_row_ctrl_pkg::*;
#(
   parameter int NUM_PE    = NUM_PE_DEF,
   parameter int MUL_LAT   = MUL_LAT_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input logic          clk,
   input logic          rst,
   pe_row_ctrl_if.slave bus_io
);
   localparam int WW  = NUM_PE > 1 ? $clog2(NUM_PE) : 1;
   localparam int WDW = $clog2(MUL_LAT + 3);
   state_e               state_q;
   logic [CNT_WIDTH-1:0] n_q, issued_q, cnt_q, cnt_d;
   logic [WW-1:0]        w_idx_q;
   logic [WDW-1:0]       wd_q;
   logic                 err_q, w_acc, d_acc, counting, last_w, last_d, wd_fire;
   assign bus_io.weight_req_o    = state_q == LOAD_W && n_q != '0;
   assign w_acc                  = bus_io.weight_val_i & bus_io.weight_req_o;
   assign bus_io.pe_weight_val_o = w_acc ? NUM_PE'(1) << w_idx_q : '0;
   assign bus_io.data_req_o      = state_q == STREAM && issued_q < n_q;
   assign d_acc                  = bus_io.data_val_i & bus_io.data_req_o;
   assign bus_io.pe_data_val_o   = d_acc;
   assign bus_io.out_cnt_o       = cnt_q;
   assign bus_io.busy_o          = state_q != IDLE;
   assign bus_io.done_o          = state_q == DONE;
   assign bus_io.err_o           = err_q;
   // returns only count while the row can legitimately be producing them
   assign counting = (state_q == STREAM || state_q == DRAIN) && bus_io.psum_val_i;
   assign cnt_d    = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
   assign last_w   = w_idx_q == WW'(NUM_PE - 1);
   assign last_d   = issued_q + CNT_WIDTH'(1) == n_q;
   assign wd_fire  = !bus_io.psum_val_i && wd_q == WDW'(MUL_LAT + 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         n_q      <= '0;
         issued_q <= '0;
         cnt_q    <= '0;
         w_idx_q  <= '0;
         wd_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         if (counting) begin
            cnt_q <= cnt_d;
            if (cnt_q >= n_q) err_q <= 1'b1;
         end
         case (state_q)
            IDLE: if (bus_io.start_i) begin
               n_q     <= bus_io.num_out_i;
               cnt_q   <= '0;
               err_q   <= 1'b0;
               w_idx_q <= '0;
               state_q <= LOAD_W;
            end
            LOAD_W: if (n_q == '0) state_q <= DONE;
            else if (w_acc) begin
               w_idx_q <= w_idx_q + WW'(1);
               if (last_w) begin
                  issued_q <= '0;
                  state_q  <= STREAM;
               end
            end
            STREAM: begin
               wd_q <= '0;
               if (d_acc) begin
                  issued_q <= issued_q + CNT_WIDTH'(1);
                  if (last_d) state_q <= DRAIN;
               end
            end
            // silence for MUL_LAT+2 cycles means a return was lost
            DRAIN: if (cnt_q == n_q) state_q <= DONE;
            else if (wd_fire) begin
               err_q   <= 1'b1;
               state_q <= DONE;
            end else wd_q <= bus_io.psum_val_i ? '0 : wd_q + WDW'(1);
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_row_ctrl.sv
// tb_pe_row_ctrl: directed jobs against pe_row_ctrl with a fixed-latency PE row model and a job scoreboard.
module tb_pe_row_ctrl;
   import pe_row_ctrl_pkg::*;
   localparam int NUM_PE = 3, MUL_LAT = 3, CW = 8;
   typedef struct {int cnt; int err; int nw; int nd; int reqs; int lat;} job_t;
   logic clk = 1'b0, rst = 1'b1;
   logic [MUL_LAT:0] pipe = '0;
   logic s_dv = 1'b0, inj = 1'b0, drop = 1'b0;
   job_t jq[$];
   int wq[$];
   int ncmp = 0, nbad = 0, cyc = 0, ref_c = 0, wk = 0, wcyc = 0, nw = 0, nd = 0, nreq = 0, cur_n = 0;
   always #5 clk = ~clk;
   pe_row_ctrl_if #(.NUM_PE(NUM_PE), .CNT_WIDTH(CW)) bus ();
   pe_row_ctrl #(.NUM_PE(NUM_PE), .MUL_LAT(MUL_LAT), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus_io(bus));
   // PE row: a data strobe returns as a psum MUL_LAT+1 cycles later
   assign bus.psum_val_i = pipe[MUL_LAT] | inj;
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      pipe <= rst ? '0 : {pipe[MUL_LAT-1:0], s_dv};
   end
   task automatic chk(string name, int act, int exp);
      ncmp++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      job_t j;
      if (bus.start_i && !bus.busy_o && !rst) begin
         ref_c = cyc; wk = 0; nw = 0; nd = 0; nreq = 0;
      end
      s_dv = bus.pe_data_val_o && !(drop && nd == cur_n - 1);
      if (bus.psum_val_i) ref_c = cyc;
      if (bus.weight_req_o || bus.data_req_o) nreq++;
      if (bus.pe_data_val_o) nd++;
      if (bus.pe_weight_val_o != '0) begin
         chk("weight_strobe", int'(bus.pe_weight_val_o), wq.size() != 0 ? wq.pop_front() : -1);
         if (wk > 0) chk("weight_gap", cyc - wcyc, 1);
         wk++; wcyc = cyc; nw++;
      end
      if (bus.done_o) begin
         if (jq.size() == 0) chk("unexpected_done", jq.size(), 1);
         else begin
            j = jq.pop_front();
            chk("job_out_cnt", int'(bus.out_cnt_o), j.cnt);
            chk("job_err", int'(bus.err_o), j.err);
            chk("job_weights", nw, j.nw);
            chk("job_data", nd, j.nd);
            chk("job_reqs", nreq, j.reqs);
            chk("job_latency", cyc - ref_c, j.lat);
         end
      end
   end
   task automatic start_job(int n, int cnt, int err, int dn, int reqs, int lat, bit expect_done);
      job_t j = '{cnt, err, (n != 0) ? NUM_PE : 0, dn, reqs, lat};
      cur_n = n;
      if (n != 0) for (int i = 0; i < NUM_PE; i++) wq.push_back(1 << i);
      if (expect_done) jq.push_back(j);
      @(posedge clk); #1 bus.start_i = 1'b1; bus.num_out_i = CW'(n);
      @(posedge clk); #1 bus.start_i = 1'b0;
      @(negedge clk);
      chk("start_err_clr", int'(bus.err_o), 0);
      chk("start_cnt_clr", int'(bus.out_cnt_o), 0);
      chk("start_busy", int'(bus.busy_o), 1);
   endtask
   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = bus.done_o;
      end
      chk("done_timeout", int'(seen), 1);
      @(negedge clk);
      chk("done_pulse", int'({bus.done_o, bus.busy_o}), 0);
   endtask
   task automatic wait_strobes(int k);
      int c = 0;
      for (int i = 0; i < 100 && c < k; i++) begin
         @(negedge clk);
         c += int'(bus.pe_data_val_o);
      end
      chk("strobe_timeout", c, k);
   endtask
   initial begin
      bus.start_i = 1'b0; bus.num_out_i = '0; bus.weight_val_i = 1'b1; bus.data_val_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(bus.busy_o), 0);
      chk("rst_done_err", int'({bus.done_o, bus.err_o}), 0);
      chk("rst_out_cnt", int'(bus.out_cnt_o), 0);
      chk("rst_reqs", int'({bus.weight_req_o, bus.data_req_o, bus.pe_weight_val_o, bus.pe_data_val_o}), 0);
      // basic job, continuous valids
      start_job(4, 4, 0, 4, 7, 2, 1'b1);
      wait_done();
      // empty job skips loads and streaming
      start_job(0, 0, 0, 0, 0, 2, 1'b1);
      wait_done();
      // 5-cycle data stall mid-stream
      start_job(4, 4, 0, 4, 12, 2, 1'b1);
      wait_strobes(2);
      @(posedge clk); #1 bus.data_val_i = 1'b0;
      repeat (5) @(posedge clk);
      #1 bus.data_val_i = 1'b1;
      wait_done();
      // last return lost: watchdog fires after MUL_LAT+2 silent cycles
      drop = 1'b1;
      start_job(4, 3, 1, 4, 7, MUL_LAT + 3, 1'b1);
      wait_done();
      drop = 1'b0;
      // one spurious extra return: overflow error, job still completes
      start_job(4, 5, 1, 4, 7, 1, 1'b1);
      wait_strobes(1);
      @(posedge clk); #1 inj = 1'b1;
      @(posedge clk); #1 inj = 1'b0;
      wait_done();
      start_job(2, 2, 0, 2, 5, 2, 1'b1);
      wait_done();
      // reset mid-stream aborts the job
      start_job(4, 0, 0, 0, 0, 0, 1'b0);
      wait_strobes(1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", int'(bus.busy_o), 0);
      chk("abort_strobes", int'({bus.pe_weight_val_o, bus.pe_data_val_o, bus.weight_req_o, bus.data_req_o}), 0);
      chk("abort_out_cnt", int'(bus.out_cnt_o), 0);
      @(posedge clk); #1 rst = 1'b0;
      // fresh job; a start pulse while busy must be ignored
      start_job(4, 4, 0, 4, 7, 2, 1'b1);
      wait_strobes(1);
      @(posedge clk); #1 bus.start_i = 1'b1; bus.num_out_i = CW'(2);
      @(posedge clk); #1 bus.start_i = 1'b0;
      wait_done();
      repeat (10) @(negedge clk);
      chk("queues_drained", jq.size() + wq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
